// File: rtl/contador_timer_bcd.sv
`default_nettype none
// ============================================================================
// Module      : contador_timer_bcd
// Description : BCD countdown timer (HH:MM:SS). A programmed value is loaded,
//               decremented once per TICK_DIV clocks while running, and a
//               sticky expiry flag is raised when the count reaches 00:00:00.
//               The flag is cleared only by the deactivate button.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1  system clock
//   reset           in   1  asynchronous, active-low reset
//   load            in   1  1-cycle pulse: capture in_hora/in_min/in_seg
//   in_hora         in   8  BCD hours to load
//   in_min          in   8  BCD minutes to load
//   in_seg          in   8  BCD seconds to load
//   start           in   1  1-cycle pulse: begin/resume countdown
//   pausa           in   1  1-cycle pulse: freeze countdown
//   btn_desactivar  in   1  level: acknowledge expiry
//   out_hora        out  8  current BCD hours
//   out_min         out  8  current BCD minutes
//   out_seg         out  8  current BCD seconds
//   estado          out  2  00 IDLE, 01 RUN, 10 PAUSA, 11 FIN
//   flag_fin        out  1  sticky expiry flag
// ============================================================================
module contador_timer_bcd #(
  parameter int         TICK_DIV = 100000000,
  parameter logic [7:0] HORA_MAX = 8'h23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] in_hora,
  input  logic [7:0] in_min,
  input  logic [7:0] in_seg,
  input  logic       start,
  input  logic       pausa,
  input  logic       btn_desactivar,
  output logic [7:0] out_hora,
  output logic [7:0] out_min,
  output logic [7:0] out_seg,
  output logic [1:0] estado,
  output logic       flag_fin
);

  // Prescaler counts 0..TICK_DIV-1; width covers TICK_DIV-1.
  localparam int                   c_presc_w    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
  localparam logic [7:0]           c_bcd_59     = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSA = 2'b10,
    ST_FIN   = 2'b11
  } estado_t;

  estado_t              r_estado;
  logic [7:0]           r_hora;
  logic [7:0]           r_min;
  logic [7:0]           r_seg;
  logic                 r_flag_fin;
  logic [c_presc_w-1:0] r_presc;

  logic [7:0] w_hora_nxt;
  logic [7:0] w_min_nxt;
  logic [7:0] w_seg_nxt;
  logic       w_cnt_zero;
  logic       w_dec_zero;
  logic       w_tick;

  // --------------------------------------------------------------------------
  // Load sanitising: an illegal field is replaced by 00, the other fields are
  // kept. Minutes/seconds need tens <= 5 and units <= 9.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] f_sanear_ms(input logic [7:0] v);
    logic ok;
    ok = (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    return ok ? v : 8'h00;
  endfunction

  // Hours need two decimal digits and must not exceed HORA_MAX. For legal BCD
  // the binary ordering equals the decimal ordering, so a plain compare works.
  function automatic logic [7:0] f_sanear_hora(input logic [7:0] v);
    logic ok;
    ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= HORA_MAX);
    return ok ? v : 8'h00;
  endfunction

  // Digit-wise BCD decrement of a non-zero field: x0 -> (x-1)9.
  function automatic logic [7:0] f_bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Next count on a one-second decrement, with borrow chain seg -> min -> hora.
  // An all-zero count holds, so the value can never wrap below 00:00:00.
  // --------------------------------------------------------------------------
  always_comb begin
    w_hora_nxt = r_hora;
    w_min_nxt  = r_min;
    w_seg_nxt  = r_seg;
    if (r_seg != 8'h00) begin
      w_seg_nxt = f_bcd_dec(r_seg);
    end else if (r_min != 8'h00) begin
      w_seg_nxt = c_bcd_59;
      w_min_nxt = f_bcd_dec(r_min);
    end else if (r_hora != 8'h00) begin
      w_seg_nxt  = c_bcd_59;
      w_min_nxt  = c_bcd_59;
      w_hora_nxt = f_bcd_dec(r_hora);
    end
  end

  assign w_cnt_zero = (r_hora == 8'h00) && (r_min == 8'h00) && (r_seg == 8'h00);
  assign w_dec_zero = (w_hora_nxt == 8'h00) && (w_min_nxt == 8'h00) && (w_seg_nxt == 8'h00);
  assign w_tick     = (r_presc == c_presc_last);

  // --------------------------------------------------------------------------
  // Control FSM, count registers and prescaler.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado   <= ST_IDLE;
      r_hora     <= 8'h00;
      r_min      <= 8'h00;
      r_seg      <= 8'h00;
      r_flag_fin <= 1'b0;
      r_presc    <= '0;
    end else begin
      case (r_estado)
        ST_IDLE, ST_PAUSA: begin
          // Load has priority over a simultaneous start; state is unchanged.
          if (load) begin
            r_hora <= f_sanear_hora(in_hora);
            r_min  <= f_sanear_ms(in_min);
            r_seg  <= f_sanear_ms(in_seg);
          end else if (start && !w_cnt_zero) begin
            r_estado <= ST_RUN;
            r_presc  <= '0;
          end
        end

        ST_RUN: begin
          // Pause beats a coinciding decrement edge.
          if (pausa) begin
            r_estado <= ST_PAUSA;
            r_presc  <= '0;
          end else if (w_tick) begin
            r_presc <= '0;
            r_hora  <= w_hora_nxt;
            r_min   <= w_min_nxt;
            r_seg   <= w_seg_nxt;
            if (w_dec_zero) begin
              r_estado   <= ST_FIN;
              r_flag_fin <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end

        ST_FIN: begin
          r_hora <= 8'h00;
          r_min  <= 8'h00;
          r_seg  <= 8'h00;
          if (btn_desactivar) begin
            r_estado   <= ST_IDLE;
            r_flag_fin <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_hora = r_hora;
  assign out_min  = r_min;
  assign out_seg  = r_seg;
  assign estado   = r_estado;
  assign flag_fin = r_flag_fin;

endmodule
`default_nettype wire

// File: tb/tb_contador_timer_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_timer_bcd
// Description : Self-checking bench for contador_timer_bcd (TICK_DIV = 4).
//               Reference model keeps the count as plain seconds and the
//               prescaler as elapsed cycles in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_timer_bcd;

  localparam int TICK     = 4;
  localparam int HORA_DEC = 23;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSA  = 2;
  localparam int M_FIN    = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] in_hora;
  logic [7:0] in_min;
  logic [7:0] in_seg;
  logic       start;
  logic       pausa;
  logic       btn_desactivar;
  logic [7:0] out_hora;
  logic [7:0] out_min;
  logic [7:0] out_seg;
  logic [1:0] estado;
  logic       flag_fin;

  int checks   = 0;
  int failures = 0;

  int   m_secs;
  int   m_st;
  int   m_cyc;
  logic m_flag;

  always #5 clk = ~clk;

  contador_timer_bcd #(
    .TICK_DIV(TICK),
    .HORA_MAX(8'h23)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .in_hora        (in_hora),
    .in_min         (in_min),
    .in_seg         (in_seg),
    .start          (start),
    .pausa          (pausa),
    .btn_desactivar (btn_desactivar),
    .out_hora       (out_hora),
    .out_min        (out_min),
    .out_seg        (out_seg),
    .estado         (estado),
    .flag_fin       (flag_fin)
  );

  // ------------------------------------------------------------------ model
  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic int bcd_field(input logic [7:0] v, input int max);
    int hi, lo, val;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return 0;
    val = hi * 10 + lo;
    return (val > max) ? 0 : val;
  endfunction

  function automatic logic [26:0] model_vec();
    int h, m, s;
    h = m_secs / 3600;
    m = (m_secs / 60) % 60;
    s = m_secs % 60;
    return {to_bcd(h), to_bcd(m), to_bcd(s), 2'(m_st), m_flag};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {out_hora, out_min, out_seg, estado, flag_fin};
  endfunction

  task automatic model_reset();
    m_secs = 0;
    m_st   = M_IDLE;
    m_cyc  = 0;
    m_flag = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic st, input logic pa,
                            input logic bt, input logic [7:0] h,
                            input logic [7:0] m, input logic [7:0] s);
    case (m_st)
      M_IDLE, M_PAUSA: begin
        if (ld) begin
          m_secs = bcd_field(h, HORA_DEC) * 3600 + bcd_field(m, 59) * 60 + bcd_field(s, 59);
        end else if (st && m_secs != 0) begin
          m_st  = M_RUN;
          m_cyc = 0;
        end
      end
      M_RUN: begin
        if (pa) begin
          m_st  = M_PAUSA;
          m_cyc = 0;
        end else begin
          m_cyc++;
          if (m_cyc == TICK) begin
            m_cyc = 0;
            m_secs--;
            if (m_secs == 0) begin
              m_st   = M_FIN;
              m_flag = 1'b1;
            end
          end
        end
      end
      M_FIN: begin
        if (bt) begin
          m_st   = M_IDLE;
          m_flag = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: inputs applied 1 ns after an edge, held through the next edge,
  // model advanced with the same inputs, outputs then observable at edge+1.
  task automatic tick(input logic ld, input logic st, input logic pa,
                      input logic bt, input logic [7:0] h,
                      input logic [7:0] m, input logic [7:0] s);
    load = ld; start = st; pausa = pa; btn_desactivar = bt;
    in_hora = h; in_min = m; in_seg = s;
    @(posedge clk);
    model_step(ld, st, pa, bt, h, m, s);
    #1;
    load = 1'b0; start = 1'b0; pausa = 1'b0; btn_desactivar = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    reset = 1'b0; load = 1'b0; start = 1'b0; pausa = 1'b0; btn_desactivar = 1'b0;
    in_hora = 8'h00; in_min = 8'h00; in_seg = 8'h00;
    model_reset();
    #2;
    checks++;
    if (dut_vec() !== 27'h0) begin
      failures++;
      $display("FAIL reset_values got=%h expected=%h", dut_vec(), 27'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++;
      $display("FAIL reset_release got=%h expected=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_countdown();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03);
    checks++;
    if ({out_hora, out_min, out_seg, estado} !== {8'h00, 8'h00, 8'h03, 2'b00}) begin
      failures++;
      $display("FAIL load_3s got=%h%h%h st=%b expected=000003 st=00", out_hora, out_min, out_seg, estado);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL countdown_c%0d got=%h expected=%h", c, dut_vec(), model_vec());
      end
      if (c == 4 || c == 8) begin
        checks++;
        if (out_seg !== ((c == 4) ? 8'h02 : 8'h01) || estado !== 2'b01) begin
          failures++;
          $display("FAIL countdown_seg_c%0d got seg=%h st=%b", c, out_seg, estado);
        end
      end
    end
    checks++;
    if ({out_seg, estado, flag_fin} !== {8'h00, 2'b11, 1'b1}) begin
      failures++;
      $display("FAIL countdown_fin got seg=%h st=%b flag=%b expected seg=00 st=11 flag=1", out_seg, estado, flag_fin);
    end
  endtask

  task automatic test_fin();
    tick(1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (dut_vec() !== {24'h000000, 2'b11, 1'b1}) begin
      failures++;
      $display("FAIL fin_ignores_pulses got=%h expected=%h", dut_vec(), {24'h000000, 2'b11, 1'b1});
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    checks++;
    if ({estado, flag_fin} !== 3'b000) begin
      failures++;
      $display("FAIL fin_ack got st=%b flag=%b expected st=00 flag=0", estado, flag_fin);
    end
    // Held button outside FIN must do nothing.
    tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h02);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    checks++;
    if (dut_vec() !== model_vec() || estado !== 2'b10) begin
      failures++;
      $display("FAIL btn_held_pausa got=%h expected=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_borrow();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(TICK);
    checks++;
    if ({out_hora, out_min, out_seg} !== 24'h005959) begin
      failures++;
      $display("FAIL borrow_hora got=%h%h%h expected=005959", out_hora, out_min, out_seg);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 8'h00);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(TICK);
    checks++;
    if ({out_hora, out_min, out_seg} !== 24'h000959) begin
      failures++;
      $display("FAIL borrow_min got=%h%h%h expected=000959", out_hora, out_min, out_seg);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++;
      $display("FAIL borrow_model got=%h expected=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_invalid_load();
    apply_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h24, 8'h5A, 8'h61);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (dut_vec() !== 27'h0) begin
      failures++;
      $display("FAIL invalid_load got=%h expected=%h", dut_vec(), 27'h0);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h23, 8'h7A, 8'h59);
    checks++;
    if ({out_hora, out_min, out_seg} !== 24'h230059) begin
      failures++;
      $display("FAIL partial_invalid got=%h%h%h expected=230059", out_hora, out_min, out_seg);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h09);
    checks++;
    if ({out_seg, estado} !== {8'h09, 2'b00}) begin
      failures++;
      $display("FAIL load_start_same got seg=%h st=%b expected seg=09 st=00", out_seg, estado);
    end
  endtask

  task automatic test_pause_on_edge();
    apply_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h05);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(TICK - 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if ({out_seg, estado} !== {8'h05, 2'b10}) begin
      failures++;
      $display("FAIL pause_wins got seg=%h st=%b expected seg=05 st=10", out_seg, estado);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL pause_hold_%0d got=%h expected=%h", i, dut_vec(), model_vec());
      end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(TICK - 1);
    checks++;
    if ({out_seg, estado} !== {8'h05, 2'b01}) begin
      failures++;
      $display("FAIL resume_early got seg=%h st=%b expected seg=05 st=01", out_seg, estado);
    end
    idle(1);
    checks++;
    if (out_seg !== 8'h04) begin
      failures++;
      $display("FAIL resume_tick got seg=%h expected seg=04", out_seg);
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h07);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    idle(2);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 27'h0) begin
      failures++;
      $display("FAIL reset_async got=%h expected=%h", dut_vec(), 27'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL reset_no_residual_%0d got=%h expected=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    logic       ld, st, pa, bt;
    logic [7:0] h, m, s;
    int         r;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(0, 99));
      ld = (r < 6);
      st = (r < 2) || (r >= 6 && r < 20);
      pa = (r >= 20 && r < 23);
      bt = (r >= 23 && r < 29);
      if ($urandom_range(0, 9) == 0) begin
        h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
      end else begin
        h = ($urandom_range(0, 19) == 0) ? to_bcd(int'($urandom_range(0, 23))) : 8'h00;
        m = to_bcd(int'($urandom_range(0, 1)));
        s = to_bcd(int'($urandom_range(0, 12)));
      end
      tick(ld, st, pa, bt, h, m, s);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL random_%0d got=%h expected=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_fin();
    test_borrow();
    test_invalid_load();
    test_pause_on_edge();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
